uart_rx_sipo: RTL

UART_RX_SIPO -- requirements
Module: uart_rx_sipo

---
 rtl/uart_rx_sipo.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sipo.sv
// UART receiver: 2-flop synchronized serial input, 8 data bits LSB first, one parity bit, one stop bit.
// Samples are taken mid-bit using an oversampling tick counter running on baud_clk.
module uart_rx_sipo #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       baud_clk,
  input  logic       rst_n,
  input  logic       data_rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       active_flag,
  output logic       done_flag
);

  localparam int unsigned TickW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e           r_state, w_state_d;
  logic             r_sync1, r_rx_s;
  logic             r_armed, w_armed_d;
  logic [TickW-1:0] r_tick, w_tick_d;
  logic [2:0]       r_bit_idx, w_bit_idx_d;
  logic [7:0]       r_shift, w_shift_d;
  logic             r_par, w_par_d;
  logic [7:0]       r_data, w_data_d;
  logic             r_valid, w_valid_d;
  logic             r_perr, w_perr_d;
  logic             r_ferr, w_ferr_d;
  logic             w_tick_last;
  logic [TickW-1:0] w_tick_inc;

  assign w_tick_last = (r_tick == TickLast);
  assign w_tick_inc  = w_tick_last ? '0 : r_tick + 1'b1;

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= StIdle;
      r_armed   <= 1'b1;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1   <= data_rx;
      r_rx_s    <= r_sync1;
      r_state   <= w_state_d;
      r_armed   <= w_armed_d;
      r_tick    <= w_tick_d;
      r_bit_idx <= w_bit_idx_d;
      r_shift   <= w_shift_d;
      r_par     <= w_par_d;
      r_data    <= w_data_d;
      r_valid   <= w_valid_d;
      r_perr    <= w_perr_d;
      r_ferr    <= w_ferr_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_armed_d   = r_armed;
    w_tick_d    = r_tick;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_par_d     = r_par;
    w_data_d    = r_data;
    w_valid_d   = 1'b0;
    w_perr_d    = r_perr;
    w_ferr_d    = r_ferr;

    unique case (r_state)
      StIdle: begin
        w_tick_d = '0;
        if (r_rx_s) begin
          w_armed_d = 1'b1;
        end else if (r_armed) begin
          w_state_d = StStart;
        end
      end

      StStart: begin
        w_tick_d = r_tick + 1'b1;
        if (r_tick == TickMid) begin
          w_tick_d = '0;
          if (r_rx_s) begin
            w_state_d = StIdle;
          end else begin
            w_state_d   = StData;
            w_bit_idx_d = '0;
          end
        end
      end

      StData: begin
        w_tick_d = w_tick_inc;
        if (w_tick_last) begin
          w_shift_d   = {r_rx_s, r_shift[7:1]};
          w_bit_idx_d = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_d = StParity;
          end
        end
      end

      StParity: begin
        w_tick_d = w_tick_inc;
        if (w_tick_last) begin
          w_par_d   = r_rx_s;
          w_state_d = StStop;
        end
      end

      StStop: begin
        w_tick_d = w_tick_inc;
        if (w_tick_last) begin
          w_data_d  = r_shift;
          w_perr_d  = r_par ^ (^r_shift) ^ PARITY_ODD;
          w_ferr_d  = ~r_rx_s;
          w_valid_d = 1'b1;
          // A low stop bit may be a line break: wait for idle-high before rearming.
          if (!r_rx_s) begin
            w_armed_d = 1'b0;
          end
          w_state_d = StIdle;
        end
      end

      default: begin
        w_state_d = StIdle;
        w_tick_d  = '0;
      end
    endcase
  end

  assign data_out    = r_data;
  assign rx_valid    = r_valid;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign active_flag = (r_state != StIdle);
  assign done_flag   = (r_state == StIdle) && r_armed;

endmodule
